// File: rtl/rtc_arb.sv
// rtc_arb: arbitrates the byte-strobe RTC controller port between the CPU and
// an internal engine that snapshots sec/min/hour on each tick.
// Optional feature macro: RTC_ARB_UIP_CHECK_EN (read reg 0x0A first and retry
// while the update-in-progress bit is set; abort with snap_err after RETRY_MAX).
module rtc_arb #(
    parameter int RETRY_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    // CPU side
    input  logic [6:1]  cpu_addrbus,
    input  logic [15:0] cpu_datain,
    output logic [15:0] cpu_dataout,
    input  logic        cpu_rdh_n,
    input  logic        cpu_rdl_n,
    input  logic        cpu_wrh_n,
    input  logic        cpu_wrl_n,
    output logic        cpu_dtack_n,
    // RTC controller side
    output logic [6:1]  rtc_addrbus,
    output logic [15:0] rtc_datain,
    input  logic [15:0] rtc_dataout,
    output logic        rtc_rdh_n,
    output logic        rtc_rdl_n,
    output logic        rtc_wrh_n,
    output logic        rtc_wrl_n,
    input  logic        rtc_dtack_n,
    // snapshot
    input  logic        tick,
    output logic [7:0]  snap_sec,
    output logic [7:0]  snap_min,
    output logic [7:0]  snap_hour,
    output logic        snap_valid,
    output logic        snap_err,
    output logic [7:0]  miss_cnt
);

    typedef enum logic [2:0] {IDLE, CPU, SN_ACC, SN_REL, SN_DONE} state_t;

`ifdef RTC_ARB_UIP_CHECK_EN
    localparam logic [1:0] LAST_IDX = 2'd3;  // UIP, sec, min, hour
    localparam int         RW       = $clog2(RETRY_MAX + 1);
    logic [RW-1:0] retry_cnt;
    logic          uip_flag;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;  // sec, min, hour
`endif

    state_t     state, state_nx;
    logic       pending;
    logic [1:0] idx;
    logic [7:0] sh_sec, sh_min, sh_hour;
    logic [6:1] eng_addr;
    logic       cpu_act, ds_idle, snap_req;
    logic       seq_start, cap, adv, done, abort, retry_inc;

    assign cpu_act  = ~(cpu_rdh_n & cpu_rdl_n & cpu_wrh_n & cpu_wrl_n);
    assign snap_req = pending | tick;

    // Map the access index to the RTC register word address.
    always_comb begin
        eng_addr = 6'd0;
`ifdef RTC_ARB_UIP_CHECK_EN
        case (idx)
            2'd0:    eng_addr = 6'd5;
            2'd1:    eng_addr = 6'd0;
            2'd2:    eng_addr = 6'd1;
            default: eng_addr = 6'd2;
        endcase
`else
        eng_addr = {4'd0, idx};
`endif
    end

    // Port mux: CPU passes straight through when granted, else engine drives.
    always_comb begin
        rtc_rdh_n   = 1'b1;
        rtc_rdl_n   = 1'b1;
        rtc_wrh_n   = 1'b1;
        rtc_wrl_n   = 1'b1;
        rtc_addrbus = 6'd0;
        rtc_datain  = 16'd0;
        cpu_dtack_n = 1'b1;
        cpu_dataout = 16'd0;
        if (state == CPU) begin
            rtc_rdh_n   = cpu_rdh_n;
            rtc_rdl_n   = cpu_rdl_n;
            rtc_wrh_n   = cpu_wrh_n;
            rtc_wrl_n   = cpu_wrl_n;
            rtc_addrbus = cpu_addrbus;
            rtc_datain  = cpu_datain;
            cpu_dtack_n = rtc_dtack_n;
            cpu_dataout = rtc_dataout;
        end else if (state == SN_ACC) begin
            rtc_rdh_n   = 1'b0;
            rtc_addrbus = eng_addr;
        end
    end

    assign ds_idle = rtc_rdh_n & rtc_rdl_n & rtc_wrh_n & rtc_wrl_n & rtc_dtack_n;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and engine control strobes.
    always_comb begin
        state_nx  = state;
        seq_start = 1'b0;
        cap       = 1'b0;
        adv       = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        retry_inc = 1'b0;
        case (state)
            IDLE: if (ds_idle) begin
                if (cpu_act) begin
                    state_nx = CPU;
                end else if (snap_req) begin
                    state_nx  = SN_ACC;
                    seq_start = 1'b1;
                end
            end
            CPU: if (!cpu_act && rtc_dtack_n) state_nx = IDLE;
            SN_ACC: if (!rtc_dtack_n) begin
                cap      = 1'b1;
                state_nx = SN_REL;
            end
            SN_REL: if (rtc_dtack_n) begin
`ifdef RTC_ARB_UIP_CHECK_EN
                if (idx == 2'd0 && uip_flag) begin
                    if (int'(retry_cnt) >= RETRY_MAX - 1) begin
                        abort    = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        retry_inc = 1'b1;
                        state_nx  = SN_ACC;
                    end
                end else
`endif
                if (idx == LAST_IDX) begin
                    state_nx = SN_DONE;
                end else begin
                    adv      = 1'b1;
                    state_nx = SN_ACC;
                end
            end
            SN_DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request tracking, shadow capture and snapshot publication.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            miss_cnt   <= 8'd0;
            idx        <= 2'd0;
            sh_sec     <= 8'd0;
            sh_min     <= 8'd0;
            sh_hour    <= 8'd0;
            snap_sec   <= 8'd0;
            snap_min   <= 8'd0;
            snap_hour  <= 8'd0;
            snap_valid <= 1'b0;
        end else begin
            if (tick) begin
                if (pending || state == SN_ACC || state == SN_REL) begin
                    if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
                end else begin
                    pending <= 1'b1;
                end
            end
            if (done || abort) pending <= 1'b0;

            if (seq_start)  idx <= 2'd0;
            else if (adv)   idx <= idx + 2'd1;

            if (cap) begin
                case (eng_addr)
                    6'd0:    sh_sec  <= rtc_dataout[15:8];
                    6'd1:    sh_min  <= rtc_dataout[15:8];
                    6'd2:    sh_hour <= rtc_dataout[15:8];
                    default: ;
                endcase
            end

            snap_valid <= done;
            if (done) begin
                snap_sec  <= sh_sec;
                snap_min  <= sh_min;
                snap_hour <= sh_hour;
            end
        end
    end

`ifdef RTC_ARB_UIP_CHECK_EN
    // UIP sample, consecutive-retry counter and abort pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retry_cnt <= '0;
            uip_flag  <= 1'b0;
            snap_err  <= 1'b0;
        end else begin
            if (seq_start)      retry_cnt <= '0;
            else if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
            if (cap && idx == 2'd0) uip_flag <= rtc_dataout[15];
            snap_err <= abort;
        end
    end
`else
    assign snap_err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_arb.sv
// tb_rtc_arb: directed bench for rtc_arb with a small RTC controller model
// (dtack two cycles after a strobe falls, released one cycle after strobes rise).
module tb_rtc_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:1]  cpu_addrbus = 6'd0;
    logic [15:0] cpu_datain = 16'd0;
    logic [15:0] cpu_dataout;
    logic        cpu_rdh_n = 1'b1, cpu_rdl_n = 1'b1, cpu_wrh_n = 1'b1, cpu_wrl_n = 1'b1;
    logic        cpu_dtack_n;
    logic [6:1]  rtc_addrbus;
    logic [15:0] rtc_datain;
    logic [15:0] rtc_dataout;
    logic        rtc_rdh_n, rtc_rdl_n, rtc_wrh_n, rtc_wrl_n;
    logic        rtc_dtack_n = 1'b1;
    logic        tick = 1'b0;
    logic [7:0]  snap_sec, snap_min, snap_hour, miss_cnt;
    logic        snap_valid, snap_err;

    rtc_arb #(.RETRY_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addrbus(cpu_addrbus), .cpu_datain(cpu_datain), .cpu_dataout(cpu_dataout),
        .cpu_rdh_n(cpu_rdh_n), .cpu_rdl_n(cpu_rdl_n), .cpu_wrh_n(cpu_wrh_n), .cpu_wrl_n(cpu_wrl_n),
        .cpu_dtack_n(cpu_dtack_n),
        .rtc_addrbus(rtc_addrbus), .rtc_datain(rtc_datain), .rtc_dataout(rtc_dataout),
        .rtc_rdh_n(rtc_rdh_n), .rtc_rdl_n(rtc_rdl_n), .rtc_wrh_n(rtc_wrh_n), .rtc_wrl_n(rtc_wrl_n),
        .rtc_dtack_n(rtc_dtack_n),
        .tick(tick), .snap_sec(snap_sec), .snap_min(snap_min), .snap_hour(snap_hour),
        .snap_valid(snap_valid), .snap_err(snap_err), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // cycle counter and pulse monitors
    int cyc = 0, valid_cnt = 0, err_cnt = 0, last_valid_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (snap_valid) begin valid_cnt <= valid_cnt + 1; last_valid_cyc <= cyc; end
        if (snap_err) err_cnt <= err_cnt + 1;
    end

    // RTC controller model
    logic [1:0] m_cnt = 2'd0;
    logic [5:0] m_addr = 6'd0;
    logic [7:0] m_hour = 8'h23;
    int acc_cnt = 0, uip_reads = 0, uip_target = 0;
    always @(posedge clk) begin
        if (!(rtc_rdh_n & rtc_rdl_n & rtc_wrh_n & rtc_wrl_n)) begin
            m_addr <= rtc_addrbus;
            if (m_cnt != 2'd3) m_cnt <= m_cnt + 2'd1;
            if (m_cnt >= 2'd1 && rtc_dtack_n) begin
                rtc_dtack_n <= 1'b0;
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            m_cnt <= 2'd0;
            if (!rtc_dtack_n && m_addr == 6'd5) uip_reads <= uip_reads + 1;
            rtc_dtack_n <= 1'b1;
        end
    end
    always_comb begin
        case (rtc_addrbus)
            6'd0:    rtc_dataout = 16'h5900;
            6'd1:    rtc_dataout = 16'h1200;
            6'd2:    rtc_dataout = {m_hour, 8'h00};
            6'd3:    rtc_dataout = 16'hA55A;
            6'd5:    rtc_dataout = (uip_reads < uip_target) ? 16'h8000 : 16'h0000;
            default: rtc_dataout = {10'b1100000000, rtc_addrbus};
        endcase
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // CPU access; caller is just after a posedge. Optionally pulses tick with the strobe.
    task automatic cpu_rw(input logic [5:0] a, input logic [3:0] strb, input logic [15:0] din,
                          input bit with_tick, output logic [15:0] dout, output logic [5:0] raddr,
                          output logic [3:0] rstrb, output logic [15:0] rdin,
                          output int dt_cyc, output bit ok);
        cpu_addrbus = a;
        {cpu_rdh_n, cpu_rdl_n, cpu_wrh_n, cpu_wrl_n} = strb;
        cpu_datain = din;
        if (with_tick) tick = 1'b1;
        ok = 1'b0; dout = '0; raddr = '0; rstrb = '0; rdin = '0; dt_cyc = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!cpu_dtack_n) begin
                ok = 1'b1; dout = cpu_dataout; raddr = rtc_addrbus; rdin = rtc_datain;
                rstrb = {rtc_rdh_n, rtc_rdl_n, rtc_wrh_n, rtc_wrl_n}; dt_cyc = cyc;
                break;
            end
            @(posedge clk); #1 tick = 1'b0;
        end
        @(posedge clk); #1;
        {cpu_rdh_n, cpu_rdl_n, cpu_wrh_n, cpu_wrl_n} = 4'hF;
        tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (snap_valid) begin ok = 1'b1; break; end
        end
    endtask

    typedef struct {
        logic [5:0]  addr;
        logic [3:0]  strb;   // {rdh_n, rdl_n, wrh_n, wrl_n}
        logic [15:0] din;
        logic [15:0] dout;
    } vec_t;
    vec_t vt[5];

    initial begin
        logic [15:0] dout, rdin;
        logic [5:0]  raddr;
        logic [3:0]  rstrb;
        int dt, v0, c0, a0, m0, e0;
        bit ok;
`ifdef RTC_ARB_UIP_CHECK_EN
        int lat_max = 28, n_acc = 4;
`else
        int lat_max = 22, n_acc = 3;
`endif

        vt[0] = '{6'd3,  4'b0011, 16'h0000, 16'hA55A};
        vt[1] = '{6'd0,  4'b0111, 16'h0000, 16'h5900};
        vt[2] = '{6'd2,  4'b1011, 16'h0000, 16'h2300};
        vt[3] = '{6'h10, 4'b1101, 16'hBEEF, 16'hC010};
        vt[4] = '{6'h3F, 4'b1100, 16'h1234, 16'hC03F};

        // reset state, with tick asserted to show it is ignored
        repeat (2) @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        @(negedge clk);
        chk("rst_rtc_strobes", {rtc_rdh_n, rtc_rdl_n, rtc_wrh_n, rtc_wrl_n}, 4'hF);
        chk("rst_rtc_addr_din", {rtc_addrbus, rtc_datain}, 22'd0);
        chk("rst_cpu_side", {cpu_dtack_n, cpu_dataout}, 17'h10000);
        chk("rst_snap", {snap_sec, snap_min, snap_hour, snap_valid, snap_err, miss_cnt}, 34'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_tick_ignored", valid_cnt, 0);

        // CPU pass-through vectors
        for (int i = 0; i < 5; i++) begin
            cpu_rw(vt[i].addr, vt[i].strb, vt[i].din, 1'b0, dout, raddr, rstrb, rdin, dt, ok);
            chk($sformatf("vec%0d_ack", i), ok, 1);
            chk($sformatf("vec%0d_dout", i), dout, vt[i].dout);
            chk($sformatf("vec%0d_addr", i), raddr, vt[i].addr);
            chk($sformatf("vec%0d_strb", i), rstrb, vt[i].strb);
            chk($sformatf("vec%0d_din", i), rdin, vt[i].din);
        end

        // basic snapshot on an idle bus
        v0 = valid_cnt; a0 = acc_cnt; c0 = cyc;
        pulse_tick();
        wait_valid(60, ok);
        chk("snap_seen", ok, 1);
        chk("snap_data", {snap_sec, snap_min, snap_hour}, 24'h591223);
        chk("snap_latency_ok", (cyc - c0) <= lat_max, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("snap_pulses", valid_cnt - v0, 1);
        chk("snap_accesses", acc_cnt - a0, n_acc);

        // CPU word read one cycle after tick stalls behind the snapshot
        v0 = valid_cnt;
        pulse_tick();
        cpu_rw(6'd3, 4'b0011, 16'h0, 1'b0, dout, raddr, rstrb, rdin, dt, ok);
        chk("stall_ack", ok, 1);
        chk("stall_dout", dout, 16'hA55A);
        chk("stall_valid_first", (valid_cnt - v0 == 1) && (last_valid_cyc < dt), 1);

        // CPU and tick in the same cycle: CPU first, snapshot after
        v0 = valid_cnt;
        cpu_rw(6'd3, 4'b0011, 16'h0, 1'b1, dout, raddr, rstrb, rdin, dt, ok);
        chk("prio_ack", ok, 1);
        chk("prio_dout", dout, 16'hA55A);
        wait_valid(60, ok);
        chk("prio_snap_seen", ok, 1);
        #1;
        chk("prio_valid_after_dtack", last_valid_cyc > dt, 1);
        chk("prio_miss", miss_cnt, 8'd0);

        // three extra ticks during one snapshot
        v0 = valid_cnt;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            pulse_tick();
            @(posedge clk); #1;
        end
        wait_valid(60, ok);
        chk("miss_snap_seen", ok, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("miss_cnt", miss_cnt, 8'd3);
        chk("miss_one_valid", valid_cnt - v0, 1);

`ifdef RTC_ARB_UIP_CHECK_EN
        // UIP stuck for RETRY_MAX reads: abort, snapshot untouched
        m_hour = 8'h07;
        v0 = valid_cnt; e0 = err_cnt;
        uip_target = uip_reads + 3;
        pulse_tick();
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (snap_err) begin ok = 1'b1; break; end
        end
        chk("uip_err_seen", ok, 1);
        repeat (30) @(posedge clk);
        #1;
        chk("uip_err_pulses", err_cnt - e0, 1);
        chk("uip_no_valid", valid_cnt - v0, 0);
        chk("uip_snap_kept", {snap_sec, snap_min, snap_hour}, 24'h591223);

        // UIP set for two reads, then clear: snapshot completes
        e0 = err_cnt;
        uip_target = uip_reads + 2;
        pulse_tick();
        wait_valid(80, ok);
        chk("uip2_valid", ok, 1);
        chk("uip2_data", {snap_sec, snap_min, snap_hour}, 24'h591207);
        chk("uip2_no_err", err_cnt - e0, 0);
        m_hour = 8'h23;
`endif

        // reset during the minute read
        v0 = valid_cnt;
        @(posedge clk); #1;
        pulse_tick();
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!rtc_rdh_n && rtc_addrbus == 6'd1) begin ok = 1'b1; break; end
        end
        chk("mrst_min_read_seen", ok, 1);
        rst_n = 1'b0; tick = 1'b1;
        @(posedge clk); #1;
        chk("mrst_strobes", {rtc_rdh_n, rtc_rdl_n, rtc_wrh_n, rtc_wrl_n}, 4'hF);
        chk("mrst_snap", {snap_sec, snap_min, snap_hour, snap_valid, miss_cnt}, 33'd0);
        @(posedge clk); #1 rst_n = 1'b1; tick = 1'b0;
        a0 = acc_cnt; m0 = miss_cnt;
        repeat (30) @(posedge clk);
        #1;
        chk("mrst_no_valid", valid_cnt - v0, 0);
        chk("mrst_pending_clear", acc_cnt - a0, 0);
        chk("mrst_miss_zero", m0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
